// File: rtl/phys_mem_ctrl.sv
// Physical memory controller for the CPU dev_mem_* bus, driving an external asynchronous
// 32-bit SRAM with timed read and write cycles.
//
// Ports:
//   clk, rst           rising-edge clock; synchronous active-low reset
//   dev_mem_addr       byte address from the MMU (word address is [SRAM_AW+1:2])
//   dev_mem_data_out   write data from the CPU
//   dev_mem_is_write   1 = write request, 0 = read request
//   dev_mem_data_in    read buffer returned to the CPU
//   dev_mem_busy       request pending (combinational)
//   sram_addr          SRAM word address (registered)
//   sram_data          SRAM bidirectional data bus
//   sram_ce_n/oe_n/we_n  SRAM strobes, active-low (registered)
module phys_mem_ctrl #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2,
  parameter int unsigned SRAM_AW    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dev_mem_addr,
  input  logic [31:0]        dev_mem_data_out,
  input  logic               dev_mem_is_write,
  output logic [31:0]        dev_mem_data_in,
  output logic               dev_mem_busy,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [31:0]        sram_data,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int unsigned MaxWait = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int unsigned CntW    = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [CntW-1:0] RdLoad = CntW'(READ_WAIT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StRdWait, StWrSetup, StWrPulse, StWrHold} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                tag_valid_q;
  // The latched request doubles as the tag: it only changes when leaving IDLE, which is
  // also the moment the tag is invalidated.
  logic [SRAM_AW-1:0]  addr_q;
  logic                is_write_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rd_buf_q;
  logic                ce_n_q, oe_n_q, we_n_q, drive_q;

  logic [SRAM_AW-1:0]  req_addr;
  logic                hit;
  logic                unused_addr_bits;

  assign req_addr         = dev_mem_addr[SRAM_AW+1:2];
  assign unused_addr_bits = ^{dev_mem_addr[1:0], dev_mem_addr[31:SRAM_AW+2]};

  // Write data only matters for write tags; a read hit ignores dev_mem_data_out.
  assign hit = tag_valid_q && (req_addr == addr_q) && (dev_mem_is_write == is_write_q) &&
               (!dev_mem_is_write || (dev_mem_data_out == wdata_q));

  assign dev_mem_busy    = (state_q != StIdle) || !hit;
  assign dev_mem_data_in = rd_buf_q;
  assign sram_addr       = addr_q;
  assign sram_ce_n       = ce_n_q;
  assign sram_oe_n       = oe_n_q;
  assign sram_we_n       = we_n_q;
  // drive_q is only set in write states, where oe_n_q is always 1.
  assign sram_data       = drive_q ? wdata_q : 32'hzzzz_zzzz;

  // Strobes are loaded with the values of the state being entered, so each cycle shows the
  // strobes of the state it is in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tag_valid_q <= 1'b0;
      addr_q      <= '0;
      is_write_q  <= 1'b0;
      wdata_q     <= '0;
      rd_buf_q    <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!hit) begin
            tag_valid_q <= 1'b0;
            addr_q      <= req_addr;
            is_write_q  <= dev_mem_is_write;
            wdata_q     <= dev_mem_data_out;
            ce_n_q      <= 1'b0;
            we_n_q      <= 1'b1;
            if (dev_mem_is_write) begin
              state_q <= StWrSetup;
              oe_n_q  <= 1'b1;
              drive_q <= 1'b1;
            end else begin
              state_q <= StRdWait;
              cnt_q   <= RdLoad;
              oe_n_q  <= 1'b0;
              drive_q <= 1'b0;
            end
          end
        end
        StRdWait: begin
          if (cnt_q == '0) begin
            rd_buf_q    <= sram_data;
            tag_valid_q <= 1'b1;
            state_q     <= StIdle;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrSetup: begin
          state_q <= StWrPulse;
          cnt_q   <= WrLoad;
          we_n_q  <= 1'b0;
        end
        StWrPulse: begin
          if (cnt_q == '0) begin
            state_q <= StWrHold;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrHold: begin
          tag_valid_q <= 1'b1;
          state_q     <= StIdle;
          ce_n_q      <= 1'b1;
          drive_q     <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phys_mem_ctrl.md
# phys_mem_ctrl

Physical memory controller at the far end of the CPU's `dev_mem_*` bus. It answers requests from the MMU by running timed read and write cycles on an external asynchronous 32-bit SRAM, and drives `dev_mem_busy` until each result is valid. It is instantiated beside `cpu` in the board top. Its port names match the CPU's, so `dev_mem_data_in` is an output here and `dev_mem_data_out` is an input.

## Interface
- `READ_WAIT`, default 2: cycles that `sram_oe_n` is held low before read data is sampled; must be at least 1.
- `WRITE_WAIT`, default 2: width of the `sram_we_n` low pulse, in cycles; must be at least 1.
- `SRAM_AW`, default 20: SRAM word-address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `dev_mem_addr`  in  32  byte address; word address is `dev_mem_addr[SRAM_AW+1:2]`, bits [1:0] are ignored.
- `dev_mem_data_out`  in  32  write data from the CPU.
- `dev_mem_is_write`  in  1  1 = write request, 0 = read request.
- `dev_mem_data_in`  out  32  read data to the CPU.
- `dev_mem_busy`  out  1  request pending; the CPU stalls while this is high.
- `sram_addr`  out  SRAM_AW  SRAM word address.
- `sram_data`  inout  32  SRAM data bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.

## Operation
- **Request tag.** The block keeps a completed-request tag {valid, addr[SRAM_AW+1:2], is_write, wdata}.
  - wdata is compared for writes only.
  - In IDLE, the request "hits" when the current inputs equal a valid tag.
- **`dev_mem_busy`** is combinational: `(state != IDLE) | (state == IDLE & !hit)`.
  - Always-on instruction fetch therefore stalls only while the address changes.
- **States and transitions**
  - **IDLE.** On a miss at the clock edge, latch addr/is_write/wdata, invalidate the tag, and go to RD_WAIT (read) or WR_SETUP (write).
  - **RD_WAIT.** A counter is loaded with READ_WAIT-1 and decremented each cycle. When it reaches 0, the edge samples `sram_data` into the read buffer, writes the tag (valid, is_write=0), and returns to IDLE.
  - **WR_SETUP.** One cycle, then WR_PULSE.
  - **WR_PULSE.** WRITE_WAIT cycles, then WR_HOLD.
  - **WR_HOLD.** One cycle, then write the tag (valid, is_write=1) and return to IDLE.
- **SRAM outputs** are registered. The value seen in a cycle is the one belonging to the state occupied in that cycle:
  - IDLE: all strobes 1, `sram_data` high-Z.
  - RD_WAIT: ce_n=0, oe_n=0, we_n=1, bus high-Z.
  - WR_SETUP and WR_HOLD: ce_n=0, oe_n=1, we_n=1, bus driven with the latched wdata.
  - WR_PULSE: as above but we_n=0.
- **`sram_addr`** holds the latched word address from leaving IDLE until the next request.
- **`dev_mem_data_in`** is the read buffer. It changes only when a read completes; a write leaves it unchanged.
- **Hazards**
  - A read after a write to the same address misses (is_write differs) and performs a real SRAM read.
  - A repeated identical write hits and is not re-issued; this is acceptable because it is idempotent.
- **Protocol violation.** If inputs change while the controller is outside IDLE, the change is ignored. The latched request completes, then the new inputs are evaluated in IDLE.
- **Bus contention.** The block never drives `sram_data` in a cycle where oe_n=0.

## Timing
- **Reset values**, at the first edge with rst=0:
  - state IDLE, tag invalid, read buffer 0;
  - `dev_mem_data_in`=0, `sram_addr`=0;
  - all strobes 1, `sram_data` high-Z.
  - `dev_mem_busy` is 1 whenever the block is not in reset, because the tag is invalid.
- **Read miss.** Busy is high for READ_WAIT+1 cycles, counting from the cycle the miss is first presented. Data is valid in the first cycle busy is low. With READ_WAIT=2 this is 3 cycles.
- **Write miss.** Busy is high for WRITE_WAIT+3 cycles; with WRITE_WAIT=2 this is 5 cycles.
  - Address and data are stable for 1 cycle before we_n falls and for 1 cycle after it rises.
- **Hit.** Zero-cycle response: busy=0 in the same cycle.
- **Back-to-back misses.** At least one IDLE cycle separates two accesses, and the strobes return to 1 in it.
- **Reset mid-access.** The next edge forces IDLE. A write is abandoned with we_n=1 and the bus high-Z from the following cycle; the tag is invalidated.

## Test plan
- **Reset.** Hold rst=0 for 3 cycles, then release with addr=0, read. Strobes must be 1 and data_in=0 during reset, and busy=1 on the first cycle after release.
- **Read miss.** SRAM model word 0x4 = 0xDEADBEEF; request read of addr 0x00000010. Busy must be high for exactly 3 cycles, then data_in=0xDEADBEEF, with oe_n low for 2 cycles.
- **Repeated read.** Hold the same read for 5 more cycles. Busy must stay 0 and no further strobes may occur.
- **Write then read back.** Write 0x12345678 to 0x00000020 with WRITE_WAIT=3.
  - Busy must be high for 6 cycles and we_n low for exactly 3 cycles, with one setup and one hold cycle.
  - A following read of 0x20 must miss and return 0x12345678.
- **Mid-access input change.** Change addr from 0x10 to 0x14 during RD_WAIT. The controller must return the word at 0x10, then start a new access for 0x14 from IDLE.
- **Reset mid-write.** Assert rst in the first WR_PULSE cycle. We_n must be 1 and the bus high-Z in the next cycle, and a retry after reset must re-issue the write.
